// File: rtl/cv32e41p_log_pkg.sv
// Shared types and constants for the decode-stage event logger.
package cv32e41p_log_pkg;

    // Fixed channel order; bit c of event_i belongs to channel c.
    localparam logic [3:0] CH_ILLEGAL = 4'd0;
    localparam logic [3:0] CH_ECALL   = 4'd1;
    localparam logic [3:0] CH_EBREAK  = 4'd2;
    localparam logic [3:0] CH_EXC     = 4'd3;

    // Largest channel count the 4-bit channel field can name.
    localparam int unsigned MAX_CH = 16;

    // One buffered event record. The PC is held at full 32 bits; narrower
    // PCs are zero-extended on the way in.
    typedef struct packed {
        logic [3:0]  ch;
        logic [31:0] pc;
        logic [31:0] stamp;
    } log_entry_t;

    // Printable channel name for transcript messages.
    function automatic string ch_name(input logic [3:0] ch);
        case (ch)
            CH_ILLEGAL: return "ILLEGAL";
            CH_ECALL:   return "ECALL";
            CH_EBREAK:  return "EBREAK";
            CH_EXC:     return "EXC";
            default:    return "CH_OTHER";
        endcase
    endfunction

endpackage

// File: rtl/cv32e41p_log_fifo.sv
// Small circular FIFO for event records with synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. There is no empty-FIFO bypass: data written this cycle becomes
// visible at the next cycle.
module cv32e41p_log_fifo
    import cv32e41p_log_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = log_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  entry_t                 wdata_i,
    output entry_t                 rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned      AW         = $clog2(DEPTH);
    localparam logic [AW:0]      LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);

    entry_t        mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify push/pop: clear wins, pops need data, pushes need room or a pop.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (!clear_i) begin
            pop_ok_s  = pop_i && !empty_o;
            push_ok_s = push_i && (!full_o || pop_ok_s);
        end else begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (clear_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Record storage; cleared on reset so no stale X ever reaches the logger.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[rd_ptr_r];
    assign level_o = level_r;
    assign full_o  = (level_r == LEVEL_FULL);
    assign empty_o = (level_r == '0);

endmodule

// File: rtl/cv32e41p_event_log.sv
// Simulation-side decode event logger: per-channel saturating counters,
// a record FIFO and a rate-limited transcript printer.
module cv32e41p_event_log
    import cv32e41p_log_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned LOG_LIMIT = 4,
    parameter int unsigned PC_W      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [31:0]             hart_id_i,
    input  logic                    is_decoding_i,
    input  logic [NUM_CH-1:0]       event_i,
    input  logic [PC_W-1:0]         pc_id_i,
    input  logic                    drain_en_i,
    input  logic                    clear_i,
    output logic [NUM_CH*CNT_W-1:0] evt_count_o,
    output logic [CNT_W-1:0]        dropped_o,
    output logic [CNT_W-1:0]        suppressed_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned      PW       = $clog2(LOG_LIMIT + 1);
    localparam logic [PW-1:0]    PR_LIMIT = PW'(LOG_LIMIT);
    localparam logic [PW-1:0]    PR_ONE   = PW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_CH-1:0] ev_s;
    logic              ev_any_s;
    logic [3:0]        low_ch_s;
    logic              pop_s;
    logic              drop_s;
    log_entry_t        entry_in_s;
    log_entry_t        entry_out_s;
    logic              full_s;
    logic              empty_s;

    logic [31:0]       stamp_r;
    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic [CNT_W-1:0]  dropped_r;
    logic [CNT_W-1:0]  supp_r;
    logic [PW-1:0]     printed_r [MAX_CH];

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign ev_s     = event_i & {NUM_CH{is_decoding_i}};
    assign ev_any_s = |ev_s;
    assign pop_s    = drain_en_i && !empty_s && !clear_i;
    assign drop_s   = ev_any_s && full_s && !pop_s && !clear_i;

    // Pick the lowest active channel and build the record pushed this cycle.
    always_comb begin
        low_ch_s = 4'd0;
        for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
            low_ch_s = ev_s[c] ? 4'(c) : low_ch_s;
        end
        entry_in_s       = '0;
        entry_in_s.ch    = low_ch_s;
        entry_in_s.pc    = 32'(pc_id_i);
        entry_in_s.stamp = stamp_r;
    end

    cv32e41p_log_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (log_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (ev_any_s),
        .pop_i   (drain_en_i),
        .wdata_i (entry_in_s),
        .rdata_o (entry_out_s),
        .level_o (level_o),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Free-running cycle stamp; deliberately ignores clear_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stamp_r <= 32'd0;
        end else begin
            stamp_r <= stamp_r + 32'd1;
        end
    end

    // Per-channel saturating event counters; every gated bit counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                cnt_r[c] <= '0;
            end
        end else if (clear_i) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                cnt_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (ev_s[c]) begin
                    cnt_r[c] <= sat_inc(cnt_r[c]);
                end
            end
        end
    end

    // Count records lost because the FIFO had no room.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dropped_r <= '0;
        end else if (clear_i) begin
            dropped_r <= '0;
        end else if (drop_s) begin
            dropped_r <= sat_inc(dropped_r);
        end
    end

    // Print popped records until a channel hits its limit, then just count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            supp_r <= '0;
            for (int c = 0; c < int'(MAX_CH); c++) begin
                printed_r[c] <= '0;
            end
        end else if (clear_i) begin
            supp_r <= '0;
            for (int c = 0; c < int'(MAX_CH); c++) begin
                printed_r[c] <= '0;
            end
        end else if (pop_s) begin
            if (printed_r[entry_out_s.ch] < PR_LIMIT) begin
                $display("%t: %s (core %0d) at PC 0x%h, cycle %0d", $time,
                         ch_name(entry_out_s.ch), hart_id_i[3:0],
                         entry_out_s.pc[PC_W-1:0], entry_out_s.stamp);
                printed_r[entry_out_s.ch] <= printed_r[entry_out_s.ch] + PR_ONE;
            end else begin
                supp_r <= sat_inc(supp_r);
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cnt_out
        assign evt_count_o[g*CNT_W +: CNT_W] = cnt_r[g];
    end

    assign dropped_o    = dropped_r;
    assign suppressed_o = supp_r;
    assign full_o       = full_s;
    assign empty_o      = empty_s;

    initial begin
        $display("[cv32e41p_event_log] NUM_CH=%0d DEPTH=%0d CNT_W=%0d LOG_LIMIT=%0d PC_W=%0d",
                 NUM_CH, DEPTH, CNT_W, LOG_LIMIT, PC_W);
    end

    final begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            $display("[cv32e41p_event_log] %s count=%0d", ch_name(4'(c)), cnt_r[c]);
        end
        $display("[cv32e41p_event_log] hart %0d dropped=%0d suppressed=%0d",
                 hart_id_i, dropped_r, supp_r);
    end

endmodule

// File: tb/tb_cv32e41p_event_log.sv
// Self-checking bench for cv32e41p_event_log against a queue-based model.
module tb_cv32e41p_event_log;

    localparam int NUM_CH    = 4;
    localparam int DEPTH     = 8;
    localparam int CNT_W     = 4;
    localparam int LOG_LIMIT = 4;
    localparam int PC_W      = 32;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [31:0]             hart_id = 32'd3;
    logic                    is_dec = 1'b0;
    logic [NUM_CH-1:0]       ev = '0;
    logic [PC_W-1:0]         pc = '0;
    logic                    drain = 1'b0;
    logic                    clr = 1'b0;
    logic [NUM_CH*CNT_W-1:0] evt_count;
    logic [CNT_W-1:0]        dropped;
    logic [CNT_W-1:0]        suppressed;
    logic [LW-1:0]           level;
    logic                    full;
    logic                    empty;

    int checks = 0;
    int failures = 0;

    // Model state: raw (unsaturated) counts plus a queue of channel ids.
    int m_cnt [NUM_CH];
    int m_printed [NUM_CH];
    int m_drop;
    int m_supp;
    int m_q [$];

    cv32e41p_event_log #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .LOG_LIMIT(LOG_LIMIT), .PC_W(PC_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .hart_id_i(hart_id),
        .is_decoding_i(is_dec), .event_i(ev), .pc_id_i(pc),
        .drain_en_i(drain), .clear_i(clr),
        .evt_count_o(evt_count), .dropped_o(dropped),
        .suppressed_o(suppressed), .level_o(level),
        .full_o(full), .empty_o(empty)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [NUM_CH*CNT_W-1:0] exp_cnt();
        logic [NUM_CH*CNT_W-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(sat(m_cnt[c]));
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0;
            m_printed[c] = 0;
        end
        m_drop = 0;
        m_supp = 0;
        m_q.delete();
    endtask

    // One clock of the logger's rules, applied to the inputs seen at the edge.
    task automatic model_step(input logic [NUM_CH-1:0] e_raw, input logic dec,
                              input logic dr, input logic cl);
        logic [NUM_CH-1:0] e;
        int pre;
        bit do_pop;
        int ch;
        e = dec ? e_raw : '0;
        if (cl) begin
            model_reset();
        end else begin
            pre = m_q.size();
            do_pop = dr && (pre > 0);
            for (int c = 0; c < NUM_CH; c++) if (e[c]) m_cnt[c]++;
            if (do_pop) begin
                ch = m_q.pop_front();
                if (m_printed[ch] < LOG_LIMIT) m_printed[ch]++;
                else m_supp++;
            end
            if (e != '0) begin
                ch = 0;
                while (!e[ch]) ch++;
                if (pre < DEPTH || do_pop) m_q.push_back(ch);
                else m_drop++;
            end
        end
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, settle at negedge.
    task automatic step(input logic [NUM_CH-1:0] e, input logic dec,
                        input logic [PC_W-1:0] p, input logic dr, input logic cl);
        ev = e; is_dec = dec; pc = p; drain = dr; clr = cl;
        @(posedge clk);
        model_step(e, dec, dr, cl);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (evt_count !== '0) begin failures++; $display("FAIL reset_cnt: got %h expected 0", evt_count); end
        checks++; if (dropped !== '0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", dropped); end
        checks++; if (suppressed !== '0) begin failures++; $display("FAIL reset_supp: got %0d expected 0", suppressed); end
        checks++; if (level !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL reset_flags: got full=%b empty=%b expected 0/1", full, empty); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        step(4'b0001, 1'b1, 32'h80, 1'b1, 1'b0);
        checks++; if (level !== LW'(1)) begin failures++; $display("FAIL single_level_push: got %0d expected 1", level); end
        step(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (evt_count[0 +: CNT_W] !== CNT_W'(1)) begin failures++; $display("FAIL single_cnt0: got %0d expected 1", evt_count[0 +: CNT_W]); end
        checks++; if (level !== LW'(0)) begin failures++; $display("FAIL single_level_pop: got %0d expected 0", level); end
        checks++; if (suppressed !== CNT_W'(m_supp)) begin failures++; $display("FAIL single_supp: got %0d expected %0d", suppressed, m_supp); end
    endtask

    task automatic test_multi_hot();
        step(4'b0110, 1'b1, 32'h1234, 1'b0, 1'b0);
        checks++; if (evt_count !== exp_cnt()) begin failures++; $display("FAIL multi_cnt: got %h expected %h", evt_count, exp_cnt()); end
        checks++; if (level !== LW'(1)) begin failures++; $display("FAIL multi_level: got %0d expected 1", level); end
        step(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (level !== LW'(0) || suppressed !== CNT_W'(0)) begin failures++; $display("FAIL multi_drain: got level=%0d supp=%0d expected 0/0", level, suppressed); end
    endtask

    task automatic test_full();
        step('0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        checks++; if (level !== LW'(8) || full !== 1'b1) begin failures++; $display("FAIL full_level: got %0d full=%b expected 8/1", level, full); end
        checks++; if (dropped !== CNT_W'(2)) begin failures++; $display("FAIL full_dropped: got %0d expected 2", dropped); end
        checks++; if (evt_count[0 +: CNT_W] !== CNT_W'(10)) begin failures++; $display("FAIL full_cnt0: got %0d expected 10", evt_count[0 +: CNT_W]); end
        for (int i = 0; i < 8; i++) step('0, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (suppressed !== CNT_W'(4)) begin failures++; $display("FAIL full_supp: got %0d expected 4", suppressed); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) step(4'b0100, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        step(4'b0001, 1'b1, 32'h300, 1'b1, 1'b0);
        checks++; if (level !== LW'(8)) begin failures++; $display("FAIL pushpop_level: got %0d expected 8", level); end
        checks++; if (dropped !== CNT_W'(2)) begin failures++; $display("FAIL pushpop_dropped: got %0d expected 2", dropped); end
        for (int i = 0; i < 8; i++) step('0, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (suppressed !== CNT_W'(sat(m_supp)) || level !== LW'(0)) begin failures++; $display("FAIL pushpop_drain: got supp=%0d level=%0d expected %0d/0", suppressed, level, sat(m_supp)); end
    endtask

    task automatic test_saturate_clear();
        for (int i = 0; i < 20; i++) step(4'b1000, 1'b1, 32'h400, 1'b1, 1'b0);
        checks++; if (evt_count[3*CNT_W +: CNT_W] !== CNT_W'(15)) begin failures++; $display("FAIL sat_cnt3: got %0d expected 15", evt_count[3*CNT_W +: CNT_W]); end
        step(4'b1000, 1'b1, 32'h404, 1'b1, 1'b1);
        checks++; if (evt_count !== '0 || empty !== 1'b1) begin failures++; $display("FAIL clear_state: got cnt=%h empty=%b expected 0/1", evt_count, empty); end
        checks++; if (dropped !== '0 || suppressed !== '0) begin failures++; $display("FAIL clear_stats: got drop=%0d supp=%0d expected 0/0", dropped, suppressed); end
        step('0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (evt_count !== '0 || level !== '0) begin failures++; $display("FAIL clear_event_lost: got cnt=%h level=%0d expected 0/0", evt_count, level); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(NUM_CH'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 32'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 59) == 0));
            checks++; if (evt_count !== exp_cnt()) begin failures++; $display("FAIL rnd_cnt[%0d]: got %h expected %h", i, evt_count, exp_cnt()); end
            checks++; if (dropped !== CNT_W'(sat(m_drop))) begin failures++; $display("FAIL rnd_drop[%0d]: got %0d expected %0d", i, dropped, sat(m_drop)); end
            checks++; if (suppressed !== CNT_W'(sat(m_supp))) begin failures++; $display("FAIL rnd_supp[%0d]: got %0d expected %0d", i, suppressed, sat(m_supp)); end
            checks++; if (level !== LW'(m_q.size())) begin failures++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, level, m_q.size()); end
            checks++; if (full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)) begin failures++; $display("FAIL rnd_flags[%0d]: got full=%b empty=%b for level %0d", i, full, empty, m_q.size()); end
        end
    endtask

    task automatic test_async_reset();
        step('0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0010, 1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        step('0, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (level !== LW'(5)) begin failures++; $display("FAIL async_pre_level: got %0d expected 5", level); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (level !== '0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL async_fifo: got level=%0d empty=%b full=%b expected 0/1/0", level, empty, full); end
        checks++; if (evt_count !== '0 || dropped !== '0 || suppressed !== '0) begin failures++; $display("FAIL async_stats: got cnt=%h drop=%0d supp=%0d expected 0", evt_count, dropped, suppressed); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step('0, 1'b0, '0, 1'b1, 1'b0);
        step('0, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (level !== '0 || suppressed !== '0) begin failures++; $display("FAIL async_after: got level=%0d supp=%0d expected 0/0", level, suppressed); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_multi_hot();
        test_full();
        test_full_push_pop();
        test_saturate_clear();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cv32e41p_event_log.md
Name: cv32e41p_event_log

Overview:
Parametrised simulation-side event logger, the successor to the core parameter/illegal-instruction logger. It monitors NUM_CH decode-stage event channels and keeps a saturating count per channel. Event records (channel, PC, cycle stamp) are buffered in a FIFO and drained to the transcript under a per-channel print limit. Counters are exposed as ports so the bench can check them without parsing the log. It is instantiated beside the core and is not part of the synthesised netlist.

Parameters:
NUM_CH, 4, number of event channels (1..16); channel order is fixed by package constants.
DEPTH, 8, FIFO depth in entries (power of two, >=2).
CNT_W, 16, width of every saturating counter.
LOG_LIMIT, 4, maximum messages printed per channel; later events are counted but not printed.
PC_W, 32, PC width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
hart_id_i  in  32  hart id; bits [3:0] appear in messages
is_decoding_i  in  1  qualifies event_i
event_i  in  NUM_CH  one-hot or multi-hot event strobes
pc_id_i  in  PC_W  PC of the decoding instruction
drain_en_i  in  1  allows one FIFO pop per cycle
clear_i  in  1  synchronous clear of counters and FIFO
evt_count_o  out  NUM_CH*CNT_W  per-channel event counts; channel c at [c*CNT_W +: CNT_W]
dropped_o  out  CNT_W  events lost because the FIFO was full
suppressed_o  out  CNT_W  popped records not printed because of LOG_LIMIT
level_o  out  $clog2(DEPTH)+1  FIFO occupancy
full_o  out  1  level_o == DEPTH
empty_o  out  1  level_o == 0

Behaviour:
- Clock and reset are fixed: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset (async, any time, including mid-drain): all counters, FIFO pointers, printed-per-channel counts and the cycle stamp go to 0. Outputs after reset: evt_count_o=0, dropped_o=0, suppressed_o=0, level_o=0, full_o=0, empty_o=1.
- Cycle stamp: a 32-bit counter that increments every posedge after reset, wraps at 2^32 and is not affected by clear_i.
- Gated events: ev = event_i & {NUM_CH{is_decoding_i}}, sampled at posedge.
- Counting: every set bit of ev increments its channel counter, saturating at 2^CNT_W-1. Several channels can count in the same cycle.
- Enqueue: if ev != 0, push one record {ch = lowest set index of ev, pc = pc_id_i, stamp}. Other simultaneous channels are counted but not recorded.
- Pop: happens when drain_en_i && !empty. The record is visible as printed one cycle after the event at the earliest (one-cycle latency).
- Print decision on pop: if printed[ch] < LOG_LIMIT, $display "%t: <CHNAME> (core %0d) at PC 0x%h, cycle %0d" and increment printed[ch]. Otherwise increment suppressed_o (saturating).
- Full: a push while full succeeds only if a pop occurs in the same cycle (simultaneous push/pop keeps the level unchanged). Otherwise the record is discarded and dropped_o increments (saturating); channel counters still increment.
- Empty: pop is ignored; push+drain on empty writes the entry and pops nothing that cycle (no bypass).
- Pointers: wrap modulo DEPTH. level_o is updated from registered push/pop and is never above DEPTH.
- clear_i: next edge clears evt_count_o, dropped_o, suppressed_o, printed[] and the FIFO. An event in the same cycle as clear_i is discarded and not counted. clear_i has priority over push and pop.
- initial block: $display of all parameter values, prefixed "[cv32e41p_event_log]".
- final block: prints per-channel counts, dropped_o and suppressed_o.

Decomposition:
- Package cv32e41p_log_pkg:
  - channel constants CH_ILLEGAL=0, CH_ECALL=1, CH_EBREAK=2, CH_EXC=3;
  - channel-name string array;
  - log_entry_t packed struct {ch[3:0], pc, stamp[31:0]}.
- Sub-module cv32e41p_log_fifo: parametrised by DEPTH and entry type, with push/pop/clear, level/full/empty. Same reset and clear semantics as above.
- Counting and printing stay in the top.

Test Plan:
1. Reset, then event_i=4'b0001 with is_decoding_i=1 at PC 0x80 and drain_en_i=1 -> next cycle one ILLEGAL message with PC 0x00000080; evt_count_o[ch0]=1, level_o returns to 0.
2. event_i=4'b0110 in one cycle -> ch1=1 and ch2=1 counts; a single ECALL record is queued.
3. drain_en_i=0, 10 consecutive ch0 events (DEPTH=8) -> level_o=8, full_o=1, dropped_o=2, ch0 count=10. Then drain 8 -> 4 printed, suppressed_o=4.
4. FIFO full, event while drain_en_i=1 -> level_o stays 8, dropped_o unchanged.
5. CNT_W=4, 20 ch3 events -> ch3 count saturates at 15; clear_i pulse -> all counters 0, empty_o=1; an event in the clear cycle is not counted.
6. Assert rst_ni low asynchronously mid-drain with level_o=5 -> outputs return to reset values immediately without waiting for a clock edge; no further messages.
